// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory write port: packs bytes
// little-endian into 32-bit words and writes them at consecutive addresses from 0.
module instr_mem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_word_len,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_word_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W:0]   r_len;
  logic [1:0]        r_idx;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_done;
  logic [ADDR_W:0]   r_word_count;
  logic [ADDR_W:0]   w_len_clamped;
  logic              w_last;

  // Clamping the length to the memory depth guarantees the address never wraps.
  assign w_len_clamped = (i_word_len > DEPTH) ? DEPTH : i_word_len;
  assign w_last        = ((r_word_count + CNT_ONE) == r_len);

  assign o_byte_ready = (r_state == ST_LOAD);
  assign o_wr_en      = (r_state == ST_WRITE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_done       = r_done;
  assign o_word_count = r_word_count;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start && (w_len_clamped != CNT_ZERO)) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_byte_valid && (r_idx == 2'd3)) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (w_last) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: length latch, byte assembly, address and progress tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len        <= CNT_ZERO;
      r_idx        <= 2'd0;
      r_wr_addr    <= ADDR_ZERO;
      r_wr_data    <= 32'd0;
      r_done       <= 1'b0;
      r_word_count <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len        <= w_len_clamped;
            r_idx        <= 2'd0;
            r_wr_addr    <= ADDR_ZERO;
            r_word_count <= CNT_ZERO;
            r_done       <= (w_len_clamped == CNT_ZERO);
          end
        end
        ST_LOAD: begin
          if (i_byte_valid) begin
            r_wr_data[{r_idx, 3'b000} +: 8] <= i_byte_in;
            r_idx                           <= r_idx + 2'd1;
          end
        end
        ST_WRITE: begin
          r_word_count <= r_word_count + CNT_ONE;
          r_idx        <= 2'd0;
          // The final address stays visible after the load completes.
          if (w_last) begin
            r_done <= 1'b1;
          end else begin
            r_wr_addr <= r_wr_addr + ADDR_ONE;
          end
        end
        default: begin
          r_idx <= 2'd0;
        end
      endcase
    end
  end

endmodule
